// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a
// bounded per-owner hold time; feeds the Y0..Y3 inputs of the 4-to-2 encoder.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam bit         HOLD_LIMITED = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST    = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] hold_q,  hold_d;
  logic       valid_q;

  logic [1:0] owner;
  logic [3:0] others;
  logic       do_grant;
  logic [1:0] grant_idx;

  function automatic logic [3:0] dec(input logic [1:0] idx);
    dec = 4'b0001 << idx;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] oh);
    case (oh)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  // First set bit of m scanning circularly from s; caller guarantees m != 0.
  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] s);
    logic [1:0] idx;
    logic       found;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = s + 2'(k);
      if (!found && m[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    do_grant  = 1'b0;
    grant_idx = '0;
    owner     = enc(gnt_q);
    others    = req & ~dec(owner);

    if (state_q == ST_IDLE) begin
      if (|req) begin
        do_grant  = 1'b1;
        grant_idx = pick(req, ptr_q);
      end
    end else begin
      if (!req[owner]) begin
        // Release wins over a coinciding expiry; handoff happens on this edge.
        if (|others) begin
          do_grant  = 1'b1;
          grant_idx = pick(others, owner + 2'd1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end else if (HOLD_LIMITED && (hold_q == HOLD_LAST)) begin
        // Owner is scanned last, so it is re-granted only when alone.
        do_grant  = 1'b1;
        grant_idx = pick(req, owner + 2'd1);
      end else begin
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
      end
    end

    if (do_grant) begin
      state_d = ST_GRANT;
      gnt_d   = dec(grant_idx);
      ptr_d   = grant_idx + 2'd1;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= |gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: four instances with different HOLD_MAX
// values, hand-computed grant sequences, and a per-cycle one-hot monitor.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req8, req1, req4, req0;
  logic [3:0] gnt8, gnt1, gnt4, gnt0;
  logic       gv8, gv1, gv4, gv0;

  int total;
  int bad;
  bit sb_en;

  rr_arbiter_4 u8 (.clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .gnt_valid(gv8));
  rr_arbiter_4 #(.HOLD_MAX(1)) u1 (.clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1), .gnt_valid(gv1));
  rr_arbiter_4 #(.HOLD_MAX(4)) u4 (.clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .gnt_valid(gv4));
  rr_arbiter_4 #(.HOLD_MAX(0)) u0 (.clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .gnt_valid(gv0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb_en) begin
      total++;
      if (!$onehot0(gnt8) || !$onehot0(gnt1) || !$onehot0(gnt4) || !$onehot0(gnt0)) begin
        bad++;
        $display("FAIL onehot: got %b %b %b %b, required one-hot or zero each", gnt8, gnt1, gnt4, gnt0);
      end
      total++;
      if (gv8 !== |gnt8 || gv1 !== |gnt1 || gv4 !== |gnt4 || gv0 !== |gnt0) begin
        bad++;
        $display("FAIL gnt_valid: got %b%b%b%b, required %b%b%b%b",
                 gv8, gv1, gv4, gv0, |gnt8, |gnt1, |gnt4, |gnt0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (gnt8 !== 4'b0000 || gv8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: got gnt=%b valid=%b, required 0000/0", gnt8, gv8);
    end
    sb_en = 1'b1;
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt8 !== 4'b0000) begin
        bad++;
        $display("FAIL idle_%0d: got %b, required 0000", i, gnt8);
      end
    end
    req8 = 4'b0100;
    tick();
    total++;
    if (gnt8 !== 4'b0100) begin
      bad++;
      $display("FAIL pre_reset_grant: got %b, required 0100", gnt8);
    end
    #2 rst_n = 1'b0;
    req8 = 4'b0000;
    #1;
    total++;
    if (gnt8 !== 4'b0000 || gv8 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got gnt=%b valid=%b, required 0000/0", gnt8, gv8);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt8 !== 4'b0000) begin
        bad++;
        $display("FAIL post_reset_idle_%0d: got %b, required 0000", i, gnt8);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp  = 4'b0001 << i;
      req8 = exp;
      tick();
      total++;
      if (gnt8 !== exp || gv8 !== 1'b1) begin
        bad++;
        $display("FAIL single_gnt_%0d: got gnt=%b valid=%b, required %b/1", i, gnt8, gv8, exp);
      end
      req8 = 4'b0000;
      tick();
      total++;
      if (gnt8 !== 4'b0000 || gv8 !== 1'b0) begin
        bad++;
        $display("FAIL single_drop_%0d: got gnt=%b valid=%b, required 0000/0", i, gnt8, gv8);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] rq  [6] = '{4'b0010, 4'b0110, 4'b0100, 4'b1001, 4'b0001, 4'b0000};
    logic [3:0] exp [6] = '{4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      req8 = rq[i];
      tick();
      total++;
      if (gnt8 !== exp[i]) begin
        bad++;
        $display("FAIL release_step_%0d: got %b, required %b", i, gnt8, exp[i]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req1 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (gnt1 !== exp[i]) begin
        bad++;
        $display("FAIL rotation_%0d: got %b, required %b", i, gnt1, exp[i]);
      end
    end
    req1 = 4'b0000;
    tick();
    total++;
    if (gnt1 !== 4'b0000) begin
      bad++;
      $display("FAIL rotation_idle: got %b, required 0000", gnt1);
    end
  endtask

  task automatic test_expiry();
    logic [3:0] exp;
    req4 = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      exp = ((i / 4) == 1) ? 4'b0010 : 4'b0001;
      tick();
      total++;
      if (gnt4 !== exp) begin
        bad++;
        $display("FAIL expiry_shared_%0d: got %b, required %b", i, gnt4, exp);
      end
    end
    req4 = 4'b0000;
    tick();
    req4 = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (gnt4 !== 4'b0001) begin
        bad++;
        $display("FAIL expiry_regrant_%0d: got %b, required 0001", i, gnt4);
      end
    end
    req4 = 4'b0000;
    tick();
  endtask

  task automatic test_unlimited();
    req0 = 4'b1111;
    for (int i = 0; i < 301; i++) begin
      tick();
      total++;
      if (gnt0 !== 4'b0001) begin
        bad++;
        $display("FAIL unlimited_%0d: got %b, required 0001", i, gnt0);
      end
    end
    req0 = 4'b1110;
    tick();
    total++;
    if (gnt0 !== 4'b0010) begin
      bad++;
      $display("FAIL unlimited_release: got %b, required 0010", gnt0);
    end
    req0 = 4'b0000;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sb_en = 1'b0;
    req8  = '0;
    req1  = '0;
    req4  = '0;
    req0  = '0;
    test_reset();
    test_single();
    test_release();
    test_rotation();
    test_expiry();
    test_unlimited();
    tick();
    sb_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
